if_id_stage: RTL
================

Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the P7 five-stage MIPS core with precise exceptions.
- Holds the architectural fetch PC and drives the external instruction-memory address.
- Detects fetch address exceptions (AdEL) and tags each instruction with its delay-slot flag.
- Feeds the ID/EX stage: fetched instruction, its PC, pre-decode exception code and branch-delay bit. Applies stall, exception-redirect (req) and eret-kill from downstream.

Parameters:
- RESET_PC, 32'h0000_3000, fetch PC after reset.
- HANDLER_PC, 32'h0000_4180, exception handler entry.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.
- EXC_ADEL, 4'd4, excCode for a fetch address error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset; asynchronous, active-high.
- D_stall  input  1  stall request from the decode hazard unit.
- req  input  1  exception/interrupt taken this cycle (from CP0).
- D_eret  input  1  instruction currently in decode is eret.
- npc  input  32  next PC computed in decode (sequential, branch, jump or EPC).
- npc_Br  input  1  instruction in decode is a branch/jump; the next instruction is its delay slot.
- i_inst_rdata  input  32  instruction word at i_inst_addr (combinational IM read).
- i_inst_addr  output  32  fetch address = F_pc.
- F_pc  output  32  current fetch PC, passed to decode NPC as I_pc_pass.
- I_pc  output  32  PC of the instruction held in IF/ID.
- I_instr  output  32  instruction held in IF/ID.
- D_excCode  output  4  exception code attached in fetch (0 = none).
- D_bdin  output  1  held instruction is in a branch delay slot.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect) sets F_pc=RESET_PC, I_pc=0, I_instr=0, D_excCode=0, D_bdin=0. Effect is immediate; the first rising edge after release loads normally.
- Fetch check is combinational on F_pc. F_adel = (F_pc[1:0]!=0) | (F_pc<IM_LO) | (F_pc>IM_HI), unsigned compare.
- F_instr = F_adel ? 0 : i_inst_rdata. A faulting fetch never injects garbage.
- F_exc = F_adel ? EXC_ADEL : 0. F_bd = npc_Br.
- Per rising edge, strict priority:
  - 1. req: F_pc<=HANDLER_PC. IF/ID<= {I_pc=HANDLER_PC, I_instr=0, D_excCode=0, D_bdin=0}. Overrides D_stall and D_eret.
  - 2. D_stall: F_pc and all IF/ID outputs hold. D_eret has no effect this cycle.
  - 3. D_eret: F_pc<=npc (decode supplies EPC). The fetched eret+4 is killed: IF/ID<= {I_pc=F_pc, I_instr=0, D_excCode=0, D_bdin=0}.
  - 4. Normal: F_pc<=npc. IF/ID<= {I_pc=F_pc, I_instr=F_instr, D_excCode=F_exc, D_bdin=F_bd}.
- Latency: an instruction appears on I_instr exactly one edge after its address is on i_inst_addr.
- The delay slot always executes; only eret is non-delayed.
- Fetch does not raise req itself. An AdEL is carried down the pipe and reported by CP0 in M. Fetch keeps following npc until req arrives.
- F_pc wrap-around: none special. npc is used as-is. Out-of-range values fault via F_adel.
- The module has no internal state besides the PC and IF/ID registers. Outputs are registers except i_inst_addr/F_pc, which equal the PC register.

Test Plan:
- Reset then 3 free-running cycles, npc=F_pc+4, IM returns 0x3C010001 at 0x3000 -> F_pc sequence 0x3000,0x3004,0x3008,0x300C; I_pc=0x3000 with I_instr=0x3C010001 after edge 1; D_excCode=0, D_bdin=0.
- D_stall=1 for 2 cycles at F_pc=0x3008 -> F_pc, I_pc, I_instr unchanged for both edges; resume loads 0x3008 normally.
- npc_Br=1 with npc=0x3100 at F_pc=0x3010 -> I_pc=0x3010 with D_bdin=1; next F_pc=0x3100.
- npc=0x3002 (misaligned) -> next edge I_instr=0, D_excCode=4; npc=0x7000 likewise gives D_excCode=4.
- req=1 together with D_stall=1 and D_eret=1 -> F_pc=0x4180, I_pc=0x4180, I_instr=0, D_excCode=0, D_bdin=0.
- D_eret=1 with npc=EPC=0x3024 at F_pc=0x4200 -> F_pc=0x3024, I_instr=0, I_pc=0x4200. Assert reset mid-cycle afterwards -> outputs reset immediately, before the next edge.

Source files
------------

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: holds the fetch PC, flags fetch address errors,
// and applies req / stall / eret priority when loading the decode-side register.
module if_id_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC,
    parameter logic [3:0]  EXC_ADEL   = 4'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_stall,
    input  logic        req,
    input  logic        D_eret,
    input  logic [31:0] npc,
    input  logic        npc_Br,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] F_pc,
    output logic [31:0] I_pc,
    output logic [31:0] I_instr,
    output logic [3:0]  D_excCode,
    output logic        D_bdin
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  exc_q, exc_d;
    logic        bd_q, bd_d;

    logic        f_adel;
    logic [31:0] f_instr;
    logic [3:0]  f_exc;

    always_comb begin
        f_adel  = (pc_q[1:0] != 2'b00) | (pc_q < IM_LO) | (pc_q > IM_HI);
        // A faulting fetch must never pass the memory word downstream.
        f_instr = f_adel ? 32'h0000_0000 : i_inst_rdata;
        f_exc   = f_adel ? EXC_ADEL : 4'd0;
    end

    always_comb begin
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        if (req) begin
            pc_d    = HANDLER_PC;
            ipc_d   = HANDLER_PC;
            instr_d = 32'h0000_0000;
            exc_d   = 4'd0;
            bd_d    = 1'b0;
        end else if (D_stall) begin
            // hold everything
        end else if (D_eret) begin
            // eret is not delayed: squash the instruction fetched behind it
            pc_d    = npc;
            ipc_d   = pc_q;
            instr_d = 32'h0000_0000;
            exc_d   = 4'd0;
            bd_d    = 1'b0;
        end else begin
            pc_d    = npc;
            ipc_d   = pc_q;
            instr_d = f_instr;
            exc_d   = f_exc;
            bd_d    = npc_Br;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ipc_q   <= 32'h0000_0000;
            instr_q <= 32'h0000_0000;
            exc_q   <= 4'd0;
            bd_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
        end
    end

    assign i_inst_addr = pc_q;
    assign F_pc        = pc_q;
    assign I_pc        = ipc_q;
    assign I_instr     = instr_q;
    assign D_excCode   = exc_q;
    assign D_bdin      = bd_q;

endmodule
